// File: rtl/stepper_pkg.sv
// Shared types and coil lookup tables for the step/dir receive path.
// Covers both the full-step and HALF_STEP_EN half-step coil sequences.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN
  } state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam logic [15:0] FULL_LUT = {
    4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  localparam logic [31:0] HALF_LUT = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic logic [3:0] full_coil(
    input logic [1:0] idx
  );
    return FULL_LUT[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] half_coil(
    input logic [2:0] idx
  );
    return HALF_LUT[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/step_dir_decoder_sync_edge.sv
// 2-FF synchroniser plus one output register.
// EDGE=1 gives a rising-edge pulse, EDGE=0 the level, equally delayed.
module sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  if (EDGE) begin : g_edge
    logic s3_q;
    logic q_q;
    always_ff @(posedge clk) begin
      if (!rst) begin
        s3_q <= 1'b0;
        q_q  <= 1'b0;
      end else begin
        s3_q <= s2_q;
        q_q  <= s2_q & ~s3_q;
      end
    end
    assign q_o = q_q;
  end else begin : g_level
    // Extra stage keeps dir aligned with the registered step edge
    logic q_q;
    always_ff @(posedge clk) begin
      if (!rst) q_q <= 1'b0;
      else      q_q <= s2_q;
    end
    assign q_o = q_q;
  end

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: position count, period measure, coil phase.
// Define HALF_STEP_EN for the 8-entry half-step coil sequence.
module step_dir_decoder
  import stepper_pkg::*;
#(
  parameter int POS_W   = 32,
  parameter int PER_W   = 25,
  parameter int TIMEOUT = 12_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    en,
  input  logic                    clr_pos,
  output logic                    step_evt,
  output logic signed [POS_W-1:0] position,
  output logic [PER_W-1:0]        period,
  output logic                    period_valid,
  output logic                    moving,
  output logic [3:0]              coil
);

`ifdef HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  localparam logic [PER_W-1:0] GAP_MAX = '1;
  localparam logic [PER_W-1:0] TO_LAST =
    PER_W'(TIMEOUT - 1);

  function automatic logic [3:0] lut(
    input logic [PH_W-1:0] idx
  );
`ifdef HALF_STEP_EN
    return half_coil(idx);
`else
    return full_coil(idx);
`endif
  endfunction

  logic edge_s;
  logic dir_s;
  logic acc;
  logic timeout;

  state_e state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] gap_q, gap_d;
  logic [PER_W-1:0] gap_inc;
  logic             pv_q, pv_d;
  logic             mov_q, mov_d;
  logic             evt_q;
  logic [3:0]       coil_q, coil_d;

  sync_edge #(.EDGE(1'b1)) u_step (
    .clk(clk),
    .rst(rst),
    .d_i(step_in),
    .q_o(edge_s)
  );

  sync_edge #(.EDGE(1'b0)) u_dir (
    .clk(clk),
    .rst(rst),
    .d_i(dir_in),
    .q_o(dir_s)
  );

  always_comb begin
    acc     = edge_s & en;
    timeout = (gap_q == TO_LAST) & ~acc;
    gap_inc = (gap_q == GAP_MAX) ? GAP_MAX
                                 : gap_q + 1'b1;
    state_d = state_q;
    pos_d   = pos_q;
    ph_d    = ph_q;
    per_d   = per_q;
    pv_d    = pv_q;
    mov_d   = mov_q;
    gap_d   = acc ? '0 : gap_inc;

    if (acc) begin
      unique case (dir_s)
        DIR_FWD: begin
          ph_d  = ph_q + 1'b1;
          pos_d = pos_q + 1'b1;
        end
        DIR_REV: begin
          ph_d  = ph_q - 1'b1;
          pos_d = pos_q - 1'b1;
        end
      endcase
    end
    if (clr_pos) pos_d = '0;

    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = FIRST;
          mov_d   = 1'b1;
        end
      end
      FIRST, RUN: begin
        if (acc) begin
          state_d = RUN;
          mov_d   = 1'b1;
          per_d   = gap_inc;
          pv_d    = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          mov_d   = 1'b0;
          per_d   = '0;
          pv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    coil_d = en ? lut(ph_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      ph_q    <= '0;
      per_q   <= '0;
      gap_q   <= '0;
      pv_q    <= 1'b0;
      mov_q   <= 1'b0;
      evt_q   <= 1'b0;
      coil_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
      gap_q   <= gap_d;
      pv_q    <= pv_d;
      mov_q   <= mov_d;
      evt_q   <= acc;
      coil_q  <= coil_d;
    end
  end

  assign step_evt     = evt_q;
  assign position     = pos_q;
  assign period       = per_q;
  assign period_valid = pv_q;
  assign moving       = mov_q;
  assign coil         = coil_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder (TIMEOUT shortened to 1000).
// Honours HALF_STEP_EN when the design is built with it.
module tb_step_dir_decoder;

  localparam int TO = 1000;
`ifdef HALF_STEP_EN
  localparam int PH_N = 8;
`else
  localparam int PH_N = 4;
`endif

  typedef struct packed {
    logic [31:0] pos;
    logic [3:0]  coil;
    logic [24:0] per;
    logic        pv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_in;
  logic        dir_in;
  logic        en;
  logic        clr_pos;
  logic        step_evt;
  logic [31:0] position;
  logic [24:0] period;
  logic        period_valid;
  logic        moving;
  logic [3:0]  coil;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t sb[$];
  int   m_pos, m_ph, m_st, m_per, m_pv, m_last;

  logic [31:0] c_pos;
  logic [3:0]  c_coil;
  logic [24:0] c_per;
  logic        c_pv;
  logic        c_mov;

  step_dir_decoder #(
    .POS_W(32),
    .PER_W(25),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_in(step_in),
    .dir_in(dir_in),
    .en(en),
    .clr_pos(clr_pos),
    .step_evt(step_evt),
    .position(position),
    .period(period),
    .period_valid(period_valid),
    .moving(moving),
    .coil(coil)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] coil_of(input int ph);
`ifdef HALF_STEP_EN
    case (ph)
      0: return 4'b0001;
      1: return 4'b0011;
      2: return 4'b0010;
      3: return 4'b0110;
      4: return 4'b0100;
      5: return 4'b1100;
      6: return 4'b1000;
      default: return 4'b1001;
    endcase
`else
    return 4'b0001 << ph;
`endif
  endfunction

  task automatic mdl_reset();
    m_pos = 0; m_ph = 0; m_st = 0;
    m_per = 0; m_pv = 0; m_last = 0;
    sb.delete();
  endtask

  task automatic push_exp(input logic d, input bit clr);
    exp_t e;
    m_ph  = (m_ph + (d ? 1 : PH_N - 1)) % PH_N;
    m_pos = clr ? 0 : (d ? m_pos + 1 : m_pos - 1);
    if (m_st != 0) begin
      m_per = cyc - m_last;
      m_pv  = 1;
    end
    m_st   = (m_st == 0) ? 1 : 2;
    m_last = cyc;
    e.pos  = 32'(m_pos);
    e.coil = coil_of(m_ph);
    e.per  = 25'(m_per);
    e.pv   = m_pv[0];
    sb.push_back(e);
  endtask

  // One step pulse (2 cycles high); captures outputs at step_evt.
  task automatic drive_step(input logic d, input bit clr3,
                            input bit acc, output int lat);
    dir_in = d;
    @(negedge clk);
    if (acc) push_exp(d, clr3);
    step_in = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 2) step_in = 1'b0;
      if (clr3) clr_pos = (i == 3);
      if (step_evt === 1'b1 && lat == 0) begin
        lat = i;
        c_pos = position; c_coil = coil;
        c_per = period;   c_pv = period_valid;
        c_mov = moving;
      end
    end
    clr_pos = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b1; step_in = 1'b0;
    dir_in = 1'b1; clr_pos = 1'b0;
    idle(3);
    rst = 1'b1;
    mdl_reset();
    idle(2);
  endtask

  task automatic test_reset();
    int lat;
    exp_t e;
    rst = 1'b0; en = 1'b1; step_in = 1'b0;
    dir_in = 1'b1; clr_pos = 1'b0;
    idle(3);
    n_chk++;
    if ({step_evt, moving, period_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags: got %b expected 000",
               {step_evt, moving, period_valid});
    end
    n_chk++;
    if (position !== 32'd0 || period !== 25'd0) begin
      n_fail++;
      $display("FAIL rst_pos_per: got %h/%h expected 0/0",
               position, period);
    end
    n_chk++;
    if (coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_coil: got %b expected 0000", coil);
    end
    rst = 1'b1;
    mdl_reset();
    @(negedge clk);
    n_chk++;
    if (coil !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_first_coil: got %b expected 0001",
               coil);
    end
    drive_step(1'b1, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 4 || c_pos !== e.pos || c_mov !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_step: lat %0d pos %0d mov %b expected 4 %0d 1",
               lat, c_pos, c_mov, e.pos);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (position !== 32'd0 || coil !== 4'b0000 ||
        moving !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: got pos %0d coil %b mov %b expected 0 0000 0",
               position, coil, moving);
    end
    rst = 1'b1;
    mdl_reset();
    idle(2);
  endtask

  task automatic test_forward();
    int lat;
    exp_t e;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      drive_step(1'b1, 1'b0, 1'b1, lat);
      e = sb.pop_front();
      n_chk++;
      if (lat != 4 || c_pos !== e.pos || c_coil !== e.coil ||
          c_per !== e.per || c_pv !== e.pv) begin
        n_fail++;
        $display("FAIL fwd_step%0d: got lat %0d pos %0d coil %b per %0d pv %b expected 4 %0d %b %0d %b",
                 s, lat, c_pos, c_coil, c_per, c_pv,
                 e.pos, e.coil, e.per, e.pv);
      end
      idle(91);
    end
    n_chk++;
    if (position !== 32'd5 || period !== 25'd100 ||
        period_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_final: got pos %0d per %0d pv %b expected 5 100 1",
               position, period, period_valid);
    end
`ifndef HALF_STEP_EN
    n_chk++;
    if (coil !== 4'b0010) begin
      n_fail++;
      $display("FAIL fwd_coil: got %b expected 0010", coil);
    end
`endif
  endtask

  task automatic test_reverse();
    int lat;
    exp_t e;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      drive_step(1'b0, 1'b0, 1'b1, lat);
      e = sb.pop_front();
      n_chk++;
      if (lat != 4 || c_pos !== e.pos || c_coil !== e.coil) begin
        n_fail++;
        $display("FAIL rev_step%0d: got lat %0d pos %h coil %b expected 4 %h %b",
                 s, lat, c_pos, c_coil, e.pos, e.coil);
      end
      idle(11);
    end
    n_chk++;
    if (position !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL rev_final: got %h expected fffffffd",
               position);
    end
  endtask

  task automatic test_timeout();
    int lat;
    int n;
    bit bad;
    exp_t e;
    do_reset();
    drive_step(1'b1, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 4 || c_mov !== 1'b1 || c_pv !== 1'b0) begin
      n_fail++;
      $display("FAIL to_first: got lat %0d mov %b pv %b expected 4 1 0",
               lat, c_mov, c_pv);
    end
    n = 4;
    bad = 0;
    while (moving === 1'b1 && n < TO + 100) begin
      @(negedge clk);
      n++;
      if (period_valid !== 1'b0) bad = 1;
    end
    n_chk++;
    if (n != TO) begin
      n_fail++;
      $display("FAIL to_cycles: got %0d expected %0d", n, TO);
    end
    n_chk++;
    if (bad || period !== 25'd0 || moving !== 1'b0) begin
      n_fail++;
      $display("FAIL to_state: got pvbad %0d per %0d mov %b expected 0 0 0",
               bad, period, moving);
    end
    m_st = 0; m_per = 0; m_pv = 0;
    drive_step(1'b1, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 4 || c_pv !== e.pv || c_per !== e.per ||
        c_mov !== 1'b1 || c_pos !== e.pos) begin
      n_fail++;
      $display("FAIL to_idle_restart: got pv %b per %0d pos %0d expected %b %0d %0d",
               c_pv, c_per, c_pos, e.pv, e.per, e.pos);
    end
  endtask

  task automatic test_clr();
    int lat;
    exp_t e;
    do_reset();
    for (int s = 0; s < 7; s++) begin
      drive_step(1'b1, 1'b0, 1'b1, lat);
      e = sb.pop_front();
      idle(11);
    end
    n_chk++;
    if (position !== 32'd7) begin
      n_fail++;
      $display("FAIL clr_pre: got %0d expected 7", position);
    end
    drive_step(1'b1, 1'b1, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 4 || c_pos !== e.pos || c_coil !== e.coil ||
        c_per !== e.per) begin
      n_fail++;
      $display("FAIL clr_step: got pos %0d coil %b per %0d expected %0d %b %0d",
               c_pos, c_coil, c_per, e.pos, e.coil, e.per);
    end
    idle(11);
    drive_step(1'b1, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (c_pos !== e.pos || c_coil !== e.coil) begin
      n_fail++;
      $display("FAIL clr_after: got pos %0d coil %b expected %0d %b",
               c_pos, c_coil, e.pos, e.coil);
    end
  endtask

  task automatic test_enable();
    int lat;
    int lost;
    exp_t e;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      drive_step(1'b1, 1'b0, 1'b1, lat);
      e = sb.pop_front();
      idle(11);
    end
    en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_off_coil: got %b expected 0000", coil);
    end
    lost = 0;
    for (int s = 0; s < 4; s++) begin
      drive_step(1'b1, 1'b0, 1'b0, lat);
      if (lat != 0) lost++;
      idle(11);
    end
    n_chk++;
    if (lost != 0 || position !== 32'd2 ||
        coil !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_off_steps: got evts %0d pos %0d coil %b expected 0 2 0000",
               lost, position, coil);
    end
    en = 1'b1;
    @(negedge clk);
    n_chk++;
    if (coil !== coil_of(m_ph)) begin
      n_fail++;
      $display("FAIL en_restore: got %b expected %b",
               coil, coil_of(m_ph));
    end
    drive_step(1'b1, 1'b0, 1'b1, lat);
    e = sb.pop_front();
    n_chk++;
    if (lat != 4 || c_pos !== e.pos || c_coil !== e.coil ||
        c_per !== e.per || c_pv !== e.pv) begin
      n_fail++;
      $display("FAIL en_resume: got pos %0d coil %b per %0d expected %0d %b %0d",
               c_pos, c_coil, c_per, e.pos, e.coil, e.per);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      drive_step(s < 8, 1'b0, 1'b1, lat);
      e = sb.pop_front();
      n_chk++;
      if (lat != 4 || c_pos !== e.pos || c_coil !== e.coil ||
          c_per !== e.per) begin
        n_fail++;
        $display("FAIL b2b_step%0d: got lat %0d pos %0d coil %b per %0d expected 4 %0d %b %0d",
                 s, lat, c_pos, c_coil, c_per,
                 e.pos, e.coil, e.per);
      end
      if (s == 7) begin
        n_chk++;
        if (c_pos !== 32'd8 || c_coil !== 4'b0001) begin
          n_fail++;
          $display("FAIL b2b_wrap: got pos %0d coil %b expected 8 0001",
                   c_pos, c_coil);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_timeout();
    test_clr();
    test_enable();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
